// File: rtl/if_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word over a req/rdy
// handshake, and computes the next PC from the decoder's npc_op on commit.
module if_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        commit,
   input  logic [1:0]  npc_op,
   input  logic [31:0] rs_data,
   output logic [31:0] retire_cnt,
   output logic        addr_err,
   output logic        fetch_to
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_REQ,
      S_ISSUE,
      S_HALT
   } state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic [31:0]   br_off;
   logic [31:0]   npc;

   assign imem_req  = (state == S_REQ);
   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;
   assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};

   always_comb begin
      npc = pc_plus4;
      unique case (npc_op)
         2'b00: npc = pc_plus4;
         2'b01: npc = pc_plus4 + br_off;
         2'b10: npc = {pc_plus4[31:28], instr[25:0], 2'b00};
         2'b11: npc = rs_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         instr       <= 32'h0;
         instr_valid <= 1'b0;
         retire_cnt  <= 32'h0;
         addr_err    <= 1'b0;
         fetch_to    <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         unique case (state)
            S_REQ: begin
               if (imem_rdy) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  wait_cnt    <= '0;
                  state       <= S_ISSUE;
               end else if (wait_cnt == WAIT_LAST) begin
                  fetch_to <= 1'b1;
                  state    <= S_HALT;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            S_ISSUE: begin
               if (commit) begin
                  instr_valid <= 1'b0;
                  // a misaligned target halts without retiring the instruction
                  if (npc[1:0] == 2'b00) begin
                     pc         <= npc;
                     retire_cnt <= retire_cnt + 32'd1;
                     state      <= S_REQ;
                  end else begin
                     addr_err <= 1'b1;
                     state    <= S_HALT;
                  end
               end
            end
            S_HALT: begin
               instr_valid <= 1'b0;
            end
            default: state <= S_HALT;
         endcase
      end
   end

endmodule
